// File: rtl/pll_clock_supervisor.sv
// PLL lock supervisor: lock synchroniser, reset sequencing FSM,
// lock-loss counter and phased clock-enable strobe channels.
module pll_clock_supervisor #(
   parameter int CHANNELS        = 3,
   parameter int DIV_WIDTH       = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int STABLE_CYCLES   = 1024,
   parameter int RST_HOLD_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pll_lock,
   input  logic [CHANNELS*DIV_WIDTH-1:0] div,
   input  logic [CHANNELS*DIV_WIDTH-1:0] phase,
   output logic                          rst_out,
   output logic                          ready,
   output logic [CHANNELS-1:0]           ce,
   output logic [7:0]                    loss_count
);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] STABILIZE = 2'd1;
   localparam logic [1:0] HOLD      = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   localparam int CMAX = (STABLE_CYCLES > RST_HOLD_CYCLES) ?
                         STABLE_CYCLES : RST_HOLD_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   loss_evt;
   logic                   run_d;

   assign lock_s = sync_q[SYNC_STAGES-1];
   assign run_d  = (state_q == RUN) && lock_s;
   assign ready  = ~rst_out;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      loss_evt = 1'b0;
      unique case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s) state_d = STABILIZE;
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_d  = WAIT_LOCK;
               cnt_d    = '0;
               loss_evt = 1'b1;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_d  = WAIT_LOCK;
               cnt_d    = '0;
               loss_evt = 1'b1;
            end else if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d  = WAIT_LOCK;
               loss_evt = 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // rst_out releases one edge after RUN entry but asserts on the loss edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         state_q    <= WAIT_LOCK;
         cnt_q      <= '0;
         rst_out    <= 1'b1;
         loss_count <= 8'd0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_lock};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_out <= ~run_d;
         if (loss_evt && (loss_count != 8'hff))
            loss_count <= loss_count + 8'd1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_g;
      logic [DIV_WIDTH-1:0] ph_g;
      logic [DIV_WIDTH-1:0] per_new;
      logic [DIV_WIDTH-1:0] ph_new;
      logic [DIV_WIDTH-1:0] per_q;
      logic [DIV_WIDTH-1:0] ph_q;
      logic [DIV_WIDTH-1:0] cnt;
      logic                 wrap;
      logic                 ce_r;

      assign div_g   = div[g*DIV_WIDTH +: DIV_WIDTH];
      assign ph_g    = phase[g*DIV_WIDTH +: DIV_WIDTH];
      assign per_new = (div_g == '0) ? DIV_WIDTH'(1) : div_g;
      assign ph_new  = (ph_g > per_new - 1'b1) ? per_new - 1'b1 : ph_g;
      assign wrap    = (cnt == per_q - 1'b1);
      assign ce[g]   = ce_r;

      // divisor and phase only reload at run entry or period wrap
      always_ff @(posedge clk) begin
         if (rst || !run_d) begin
            cnt   <= '0;
            per_q <= DIV_WIDTH'(1);
            ph_q  <= '0;
            ce_r  <= 1'b0;
         end else if (rst_out || wrap) begin
            cnt   <= '0;
            per_q <= per_new;
            ph_q  <= ph_new;
            ce_r  <= (ph_new == '0);
         end else begin
            cnt   <= cnt + 1'b1;
            ce_r  <= ((cnt + 1'b1) == ph_q);
         end
      end
   end

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Directed bench for pll_clock_supervisor: lock latency, glitches,
// divider/phase strobes, lock loss, reset mid-run, loss saturation.
module tb_pll_clock_supervisor;

   logic        clk = 1'b0;
   logic        rst;
   logic        pll_lock;
   logic [23:0] div;
   logic [23:0] phase;
   logic        rst_out;
   logic        ready;
   logic [2:0]  ce;
   logic [7:0]  loss_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] div;
      logic [23:0] phase;
      logic [2:0]  ce;
   } vec_t;

   vec_t tv[$];

   localparam logic [23:0] S1D  = {8'd0, 8'd1, 8'd3};
   localparam logic [23:0] S1P  = {8'd7, 8'd0, 8'd2};
   localparam logic [23:0] S2D0 = {8'd0, 8'd0, 8'd4};
   localparam logic [23:0] S2D1 = {8'd0, 8'd0, 8'd2};
   localparam logic [23:0] S2P  = {8'd0, 8'd0, 8'd9};

   pll_clock_supervisor #(
      .CHANNELS(3),
      .DIV_WIDTH(8),
      .SYNC_STAGES(2),
      .STABLE_CYCLES(8),
      .RST_HOLD_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll_lock(pll_lock),
      .div(div),
      .phase(phase),
      .rst_out(rst_out),
      .ready(ready),
      .ce(ce),
      .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_scn(input logic [23:0] d0, input logic [23:0] d1,
                          input logic [23:0] p, input int chg,
                          input int n, input logic [15:0] m0);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.div   = (k < chg) ? d0 : d1;
         v.phase = p;
         v.ce    = {2'b11, m0[k]};
         tv.push_back(v);
      end
   endtask

   task automatic measure(input string name);
      int n;
      n = -1;
      for (int k = 0; k < 40; k++) begin
         tick;
         if (!rst_out) begin
            n = k;
            break;
         end
      end
      chk(name, n, 15);
      chk({name, "_ready"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic run_vectors(input string name, input int lo,
                              input int hi);
      for (int k = lo; k < hi; k++) begin
         div   = tv[k].div;
         phase = tv[k].phase;
         chk($sformatf("%s_ce%0d", name, k - lo), {29'd0, ce},
             {29'd0, tv[k].ce});
         tick;
      end
   endtask

   task automatic chk_reset_vals(input string name,
                                 input logic [7:0] exp_loss);
      chk({name, "_rst_out"}, {31'd0, rst_out}, 32'd1);
      chk({name, "_ready"}, {31'd0, ready}, 32'd0);
      chk({name, "_ce"}, {29'd0, ce}, 32'd0);
      chk({name, "_loss"}, {24'd0, loss_count}, {24'd0, exp_loss});
   endtask

   initial begin
      bit ok;
      rst      = 1'b1;
      pll_lock = 1'b0;
      div      = S1D;
      phase    = S1P;

      // ch0 P=3 F=2: strobes in RUN cycles 2,5,8
      add_scn(S1D, S1D, S1P, 9, 9, 16'b0000_0001_0010_0100);
      // ch0 P=4 F=3, then P=2 F=1 after the wrap at cycle 7
      add_scn(S2D0, S2D1, S2P, 5, 13, 16'b0000_1010_1000_1000);

      repeat (3) tick;
      rst = 1'b0;
      chk_reset_vals("reset", 8'd0);

      pll_lock = 1'b1;
      measure("powerup");
      chk("powerup_loss", {24'd0, loss_count}, 32'd0);
      run_vectors("div", 0, 9);

      pll_lock = 1'b0;
      tick;
      chk("loss_e0", {31'd0, rst_out}, 32'd0);
      tick;
      chk("loss_e1", {31'd0, rst_out}, 32'd0);
      tick;
      chk("loss_e2_rst", {31'd0, rst_out}, 32'd1);
      chk("loss_e2_ce", {29'd0, ce}, 32'd0);
      chk("loss_e2_cnt", {24'd0, loss_count}, 32'd1);

      rst   = 1'b1;
      div   = S2D0;
      phase = S2P;
      tick;
      rst = 1'b0;
      chk_reset_vals("reset2", 8'd0);

      pll_lock = 1'b1;
      repeat (5) tick;
      chk("glitch_pre", {31'd0, rst_out}, 32'd1);
      pll_lock = 1'b0;
      repeat (3) tick;
      chk("glitch_loss", {24'd0, loss_count}, 32'd1);
      pll_lock = 1'b1;
      measure("relock");
      run_vectors("phase", 9, 22);

      chk("midrun_ce", {30'd0, ce[2:1]}, 32'd3);
      rst = 1'b1;
      tick;
      chk_reset_vals("midrun", 8'd0);
      rst = 1'b0;
      measure("rerun");

      for (int i = 0; i < 260; i++) begin
         pll_lock = 1'b0;
         ok = 1'b0;
         for (int k = 0; k < 8; k++) begin
            tick;
            if (rst_out) begin
               ok = 1'b1;
               break;
            end
         end
         chk($sformatf("sat_drop%0d", i), {31'd0, ok}, 32'd1);
         if (i == 254)
            chk("sat_255", {24'd0, loss_count}, 32'd255);
         pll_lock = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 30; k++) begin
            tick;
            if (ready) begin
               ok = 1'b1;
               break;
            end
         end
         chk($sformatf("sat_lock%0d", i), {31'd0, ok}, 32'd1);
      end
      chk("sat_final", {24'd0, loss_count}, 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
